// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg: shared filter codes, controller state encoding and helpers.
package filter_ctrl_pkg;
    typedef enum logic [1:0] {COLOUR = 2'b00, BLUR = 2'b01, BRIGHTNESS = 2'b10, EDGES = 2'b11} filter_t;
    typedef enum logic [1:0] {IDLE = 2'd0, IN_FRAME = 2'd1, GAP = 2'd2} ctrl_state_t;
    localparam int NUM_FILTERS = 4;
    function automatic logic [1:0] next_filter(input logic [1:0] f);
        return 2'((int'(f) + 1) % NUM_FILTERS);
    endfunction
endpackage

// File: rtl/filter_switch_ctrl_frame_tracker.sv
// frame_tracker: follows sop/eop on the monitored stream; flags frame boundaries,
// completed frames, and a sticky error when a sop arrives inside a frame.
module frame_tracker
    import filter_ctrl_pkg::*;
#(
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   acc,
    input  logic                   sop,
    input  logic                   eop,
    output logic                   boundary,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [1:0]             state,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    ctrl_state_t st, st_nx;
    logic in_frame, start;
    assign in_frame   = st == IN_FRAME;
    assign start      = acc & sop & ~eop;
    assign boundary   = in_frame ? acc & eop : ~start;
    // a single-beat frame outside IN_FRAME still counts as a completed frame
    assign frame_done = acc & eop & (in_frame | sop);
    assign st_nx      = start ? IN_FRAME : (in_frame & acc & eop) ? GAP : st;
    assign state      = st;
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            st <= st_nx;
            if (in_frame & acc & sop) frame_err <= 1'b1;
            if (frame_done) frame_cnt <= frame_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/filter_switch_ctrl.sv
// filter_switch_ctrl: applies filter/freq requests only at frame boundaries.
// Define FILTER_AUTO_CYCLE_EN to add auto_en and step filters every FRAMES_PER_FILTER frames.
module filter_switch_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int FRAME_CNT_W       = 16,
    parameter int FRAMES_PER_FILTER = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_strobe,
    input  logic [1:0]             filter_req,
    input  logic [1:0]             freq_req,
    input  logic                   mon_sop,
    input  logic                   mon_eop,
    input  logic                   mon_valid,
    input  logic                   mon_ready,
`ifdef FILTER_AUTO_CYCLE_EN
    input  logic                   auto_en,
`endif
    output logic [1:0]             filter_num,
    output logic [1:0]             freq_flag,
    output logic                   frame_active,
    output logic                   pending,
    output logic                   switch_pulse,
    output logic                   frame_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    logic acc, boundary, frame_done, apply, step;
    logic [1:0] state, pending_filter, pending_freq;
    assign acc = mon_valid & mon_ready;
    frame_tracker #(.FRAME_CNT_W(FRAME_CNT_W)) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .acc       (acc),
        .sop       (mon_sop),
        .eop       (mon_eop),
        .boundary  (boundary),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .state     (state),
        .frame_cnt (frame_cnt)
    );
    assign frame_active = state == IN_FRAME;
    assign apply        = boundary & (pending | req_strobe);
`ifdef FILTER_AUTO_CYCLE_EN
    localparam int CW = $clog2(FRAMES_PER_FILTER) + 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_FILTER - 1);
    logic [CW-1:0] auto_cnt;
    // manual requests win: the auto step is suppressed while one is pending or strobing
    assign step = auto_en & frame_done & (auto_cnt == LAST) & ~pending & ~req_strobe;
    always_ff @(posedge clk) begin
        if (reset | ~auto_en | apply | step) auto_cnt <= '0;
        else if (frame_done) auto_cnt <= auto_cnt + 1'b1;
    end
`else
    logic unused_frame_done;
    assign step              = 1'b0;
    assign unused_frame_done = frame_done;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            filter_num     <= 2'd0;
            freq_flag      <= 2'd0;
            pending        <= 1'b0;
            pending_filter <= 2'd0;
            pending_freq   <= 2'd0;
            switch_pulse   <= 1'b0;
        end else begin
            switch_pulse <= apply | step;
            if (apply) begin
                filter_num <= req_strobe ? filter_req : pending_filter;
                freq_flag  <= req_strobe ? freq_req : pending_freq;
                pending    <= 1'b0;
            end else begin
                if (step) filter_num <= next_filter(filter_num);
                if (req_strobe) begin
                    pending        <= 1'b1;
                    pending_filter <= filter_req;
                    pending_freq   <= freq_req;
                end
            end
        end
    end
endmodule

// File: tb/tb_filter_switch_ctrl.sv
// tb_filter_switch_ctrl: vector table, corner sequences and random traffic against a frame-level model.
module tb_filter_switch_ctrl;
    logic clk = 1'b0, reset = 1'b1, req_strobe = 1'b0;
    logic [1:0] filter_req = 2'd0, freq_req = 2'd0;
    logic mon_sop = 1'b0, mon_eop = 1'b0, mon_valid = 1'b0, mon_ready = 1'b0;
    logic [1:0] filter_num, freq_flag;
    logic frame_active, pending, switch_pulse, frame_err;
    logic [15:0] frame_cnt;
`ifdef FILTER_AUTO_CYCLE_EN
    logic auto_en = 1'b0;
`endif
    int n_cmp = 0, n_bad = 0, pulses;
    bit use_model = 1'b1;
    always #5 clk = ~clk;

    filter_switch_ctrl #(.FRAME_CNT_W(16), .FRAMES_PER_FILTER(3)) dut (
        .clk(clk), .reset(reset), .req_strobe(req_strobe), .filter_req(filter_req), .freq_req(freq_req),
        .mon_sop(mon_sop), .mon_eop(mon_eop), .mon_valid(mon_valid), .mon_ready(mon_ready),
`ifdef FILTER_AUTO_CYCLE_EN
        .auto_en(auto_en),
`endif
        .filter_num(filter_num), .freq_flag(freq_flag), .frame_active(frame_active), .pending(pending),
        .switch_pulse(switch_pulse), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    // frame-level reference: whether we are inside a frame, the newest unapplied request, current selection
    bit m_in, m_err, m_pend, m_sp;
    logic [1:0] m_pf, m_pq, m_fn, m_fq;
    logic [15:0] m_cnt;

    function automatic logic [23:0] pk(input int fn, fq, a, p, sp, er, cn);
        return {2'(fn), 2'(fq), 1'(a), 1'(p), 1'(sp), 1'(er), 16'(cn)};
    endfunction

    function automatic logic [23:0] got();
        return {filter_num, freq_flag, frame_active, pending, switch_pulse, frame_err, frame_cnt};
    endfunction

    task automatic check(input string name, input logic [23:0] a, input logic [23:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, a, e, $time);
        end
    endtask

    task automatic model_tick();
        bit acc, s, e, bnd, done;
        if (reset) begin
            {m_in, m_err, m_pend, m_sp} = '0;
            {m_pf, m_pq, m_fn, m_fq} = '0;
            m_cnt = '0;
            return;
        end
        acc  = mon_valid && mon_ready;
        s    = acc && mon_sop;
        e    = acc && mon_eop;
        bnd  = m_in ? e : !(s && !e);
        done = m_in ? e : (s && e);
        if (m_in && s) m_err = 1;
        m_sp = 0;
        if (bnd && (m_pend || req_strobe)) begin
            m_fn   = req_strobe ? filter_req : m_pf;
            m_fq   = req_strobe ? freq_req : m_pq;
            m_pend = 0;
            m_sp   = 1;
        end else if (req_strobe) begin
            m_pend = 1;
            m_pf   = filter_req;
            m_pq   = freq_req;
        end
        if (done) m_cnt = m_cnt + 16'd1;
        m_in = m_in ? !e : (s && !e);
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        if (switch_pulse) pulses++;
        if (use_model) check("model", got(), pk(m_fn, m_fq, m_in, m_pend, m_sp, m_err, m_cnt));
    endtask

    task automatic drive(input logic s, input logic [1:0] fr, input logic [1:0] fq,
                         input logic so, input logic eo, input logic v, input logic r);
        req_strobe = s; filter_req = fr; freq_req = fq;
        mon_sop = so; mon_eop = eo; mon_valid = v; mon_ready = r;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        check("reset", got(), pk(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
    endtask

    typedef struct {
        logic s; logic [1:0] fr; logic [1:0] fq; logic so; logic eo; logic v; logic r;
        logic [23:0] exp;
    } vec_t;

    function automatic vec_t mkv(input int s, fr, fq, so, eo, v, r, fn, q, a, p, sp, er, cn);
        vec_t t;
        t.s = 1'(s); t.fr = 2'(fr); t.fq = 2'(fq); t.so = 1'(so); t.eo = 1'(eo); t.v = 1'(v); t.r = 1'(r);
        t.exp = pk(fn, q, a, p, sp, er, cn);
        return t;
    endfunction

`ifdef FILTER_AUTO_CYCLE_EN
    task automatic frame(input logic strobe_mid, input logic [1:0] f);
        drive(0, 0, 0, 1, 0, 1, 1); step();
        drive(strobe_mid, f, 0, 0, 0, 1, 1); step();
        drive(0, 0, 0, 0, 1, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
    endtask
`endif

    initial begin
        vec_t vecs[12];
        vecs[0]  = mkv(1, 2, 1, 0, 0, 0, 0,  2, 1, 0, 0, 1, 0, 0);
        vecs[1]  = mkv(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 0, 0, 1, 0, 1, 1,  2, 1, 1, 0, 0, 0, 0);
        vecs[3]  = mkv(1, 1, 3, 0, 0, 1, 1,  2, 1, 1, 1, 0, 0, 0);
        vecs[4]  = mkv(0, 0, 0, 0, 1, 1, 0,  2, 1, 1, 1, 0, 0, 0);
        vecs[5]  = mkv(0, 0, 0, 0, 1, 1, 1,  1, 3, 0, 0, 1, 0, 1);
        vecs[6]  = mkv(1, 3, 0, 1, 0, 1, 1,  1, 3, 1, 1, 0, 0, 1);
        vecs[7]  = mkv(0, 0, 0, 1, 0, 1, 1,  1, 3, 1, 1, 0, 1, 1);
        vecs[8]  = mkv(0, 0, 0, 1, 1, 1, 1,  3, 0, 0, 0, 1, 1, 2);
        vecs[9]  = mkv(1, 0, 2, 1, 1, 1, 1,  0, 2, 0, 0, 1, 1, 3);
        vecs[10] = mkv(0, 0, 0, 1, 1, 0, 1,  0, 2, 0, 0, 0, 1, 3);
        vecs[11] = mkv(1, 3, 3, 0, 1, 1, 1,  3, 3, 0, 0, 1, 1, 3);

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].fr, vecs[i].fq, vecs[i].so, vecs[i].eo, vecs[i].v, vecs[i].r);
            step();
            check($sformatf("vec%0d", i), got(), vecs[i].exp);
        end

        // request at beat 10 of a 100-beat frame waits for the eop
        do_reset();
        drive(0, 0, 0, 1, 0, 1, 1); step();
        for (int b = 1; b < 99; b++) begin
            drive(b == 10, 1, 0, 0, 0, 1, 1); step();
            if (b == 10) check("pend_mid", 24'(pending), 24'd1);
        end
        check("hold_mid", 24'(filter_num), 24'd0);
        drive(0, 0, 0, 0, 1, 1, 1); step();
        check("after_eop", {8'd0, filter_num, pending, frame_cnt[12:0]}, {8'd0, 2'd1, 1'b0, 13'd1});

        // two in-frame requests, eop stalled by ready=0: one switch, newest wins
        drive(0, 0, 0, 1, 0, 1, 1); step();
        pulses = 0;
        drive(1, 3, 1, 0, 0, 1, 1); step();
        drive(1, 0, 2, 0, 0, 1, 1); step();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 1, 1, 0); step();
        end
        check("stall_hold", 24'(filter_num), 24'd1);
        drive(0, 0, 0, 0, 1, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        check("stall_apply", {20'd0, filter_num, freq_flag}, 24'h000002);
        check("one_pulse", 24'(pulses), 24'd1);

        // second sop inside a frame, then reset mid-frame with a pending request
        drive(0, 0, 0, 1, 0, 1, 1); step();
        drive(0, 0, 0, 1, 0, 1, 1); step();
        check("err_set", {22'd0, frame_err, frame_active}, 24'd3);
        drive(1, 2, 2, 0, 0, 1, 1); step();
        drive(0, 0, 0, 0, 0, 1, 1); step();
        check("err_sticky", {22'd0, frame_err, pending}, 24'd3);
        do_reset();
        step();
        check("post_reset", got(), pk(0, 0, 0, 0, 0, 0, 0));

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 5) == 0, 2'($urandom), 2'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0;

`ifdef FILTER_AUTO_CYCLE_EN
        do_reset();
        use_model = 1'b0;
        auto_en = 1'b1;
        frame(0, 0); frame(0, 0);
        check("auto_f2", 24'(filter_num), 24'd0);
        frame(0, 0);
        check("auto_f3", 24'(filter_num), 24'd1);
        frame(0, 0); frame(1, 0);
        check("auto_manual", 24'(filter_num), 24'd0);
        frame(0, 0); frame(0, 0);
        check("auto_restart", 24'(filter_num), 24'd0);
        frame(0, 0);
        check("auto_f8", 24'(filter_num), 24'd1);
        auto_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
